mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width (depth = 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  CPU access request, held until ack.
REQ-006 SHALL have port op  input  2  operation: 00 READ, 01 WRITE, 10 DOUBLE (M=M+M), 11 INVERT (M=~M).
REQ-007 SHALL have port addr  input  ADDR_W  word address.
REQ-008 SHALL have port wdata  input  DATA_W  write data, used by WRITE only.
REQ-009 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  DATA_W  response data, valid while ack=1.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port ld_en  input  1  host preload strobe.
REQ-013 SHALL have ports ld_addr  input  ADDR_W and ld_data  input  DATA_W  preload address/data.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> [MODIFY] -> RESP -> IDLE.
REQ-015 SHALL, in IDLE with ld_en=1, write ld_data to ld_addr that cycle and stay in IDLE; ld_en beats req.
REQ-016 SHALL ignore ld_en outside IDLE (no write).
REQ-017 SHALL, in IDLE with req=1 and ld_en=0, capture op/addr/wdata and enter ACCESS.
REQ-018 SHALL, in ACCESS, read M[addr] into a data register; WRITE also writes wdata; READ/WRITE then go to RESP, DOUBLE/INVERT go to MODIFY.
REQ-019 SHALL, in MODIFY, write back (data<<1, truncated to DATA_W, carry dropped) for DOUBLE or ~data for INVERT, then go to RESP.
REQ-020 SHALL assert ack for exactly the RESP cycle; latency from req sample: READ/WRITE ack at edge+2, DOUBLE/INVERT at edge+3.
REQ-021 SHALL return rdata: READ old value, WRITE wdata, DOUBLE/INVERT the written-back value; rdata=0 when ack=0.
REQ-022 SHALL treat req still high in the IDLE cycle after RESP as a new request (back-to-back allowed, one idle cycle between).
REQ-023 SHALL ignore changes on op/addr/wdata after capture until return to IDLE.
REQ-024 SHALL wrap nothing: addr spans full depth, no out-of-range case.

Reset
REQ-025 SHALL, on rst_n=0, immediately force IDLE, ack=0, rdata=0, busy=0, abandoning any in-flight access.
REQ-026 SHALL leave memory contents unchanged by reset; a write scheduled in the aborted cycle SHALL NOT occur.
REQ-027 SHALL clear its data/capture registers to 0 on reset.

Configuration
REQ-028 SHALL, when MEM_PARITY_EN is defined, store an even-parity bit per word on every write (preload, WRITE, MODIFY) and add output perr (1 bit) high with ack when the word read in ACCESS has bad parity.
REQ-029 SHALL, when MEM_PARITY_EN is undefined, have no parity storage and no perr port.

Structure
REQ-030 SHALL take op encodings (OP_READ, OP_WRITE, OP_DOUBLE, OP_INVERT) and FSM state typedef from shared package cpu_pkg.
REQ-031 SHALL place the storage array (one write port, one async read port, optional parity bit) in sub-module mem_array.

Verification
REQ-032 SHALL cover: preload M[3]=0x5A, READ addr 3 -> ack at edge+2, rdata=0x5A.
REQ-033 SHALL cover: WRITE addr 7 wdata 0xC3 -> ack at edge+2, rdata=0xC3; READ 7 -> 0xC3.
REQ-034 SHALL cover: M[2]=0x81, DOUBLE addr 2 -> ack at edge+3, rdata=0x02, M[2]=0x02; INVERT addr 2 -> 0xFD.
REQ-035 SHALL cover: ld_en and req same IDLE cycle -> preload done, request served after, ack 1 cycle later than alone.
REQ-036 SHALL cover: rst_n low during MODIFY of INVERT on M[4]=0x0F -> no ack, M[4] stays 0x0F, busy=0.
REQ-037 SHALL cover (MEM_PARITY_EN): corrupt stored parity of M[5] via backdoor, READ 5 -> perr=1 with ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared op encodings and responder FSM state type.
package cpu_pkg;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_DOUBLE = 2'b10;
   localparam logic [1:0] OP_INVERT = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StModify,
      StResp
   } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// With MEM_PARITY_EN defined, an even-parity bit is kept per word and checked on read.
module mem_array #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
`ifdef MEM_PARITY_EN
   ,
   output logic              rpar_ok
`endif
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

`ifdef MEM_PARITY_EN
   logic par_q [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         par_q[waddr] <= ^wdata;
      end
   end

   assign rpar_ok = ((^mem_q[raddr]) ^ par_q[raddr]) == 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder: READ, WRITE, DOUBLE and INVERT on a small word array.
// Optional MEM_PARITY_EN adds per-word parity storage and the perr output.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy
`ifdef MEM_PARITY_EN
   ,
   output logic              perr
`endif
);

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy_q, busy_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] modified;

`ifdef MEM_PARITY_EN
   logic              mem_rpar_ok;
   logic              bad_par_q, bad_par_d;
   logic              perr_q, perr_d;
`endif

   assign modified = (op_q == OP_DOUBLE) ? {data_q[DATA_W-2:0], 1'b0} : ~data_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      data_d    = data_q;
      ack_d     = 1'b0;
      rdata_d   = '0;
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = data_q;
`ifdef MEM_PARITY_EN
      bad_par_d = bad_par_q;
      perr_d    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            // Preload has priority; a pending req waits in IDLE until ld_en drops.
            if (ld_en) begin
               mem_we    = 1'b1;
               mem_waddr = ld_addr;
               mem_wdata = ld_data;
            end else if (req) begin
               op_d    = op;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = StAccess;
            end
         end
         StAccess: begin
            data_d = mem_rdata;
`ifdef MEM_PARITY_EN
            bad_par_d = ~mem_rpar_ok;
`endif
            if (op_q == OP_WRITE) begin
               mem_we    = 1'b1;
               mem_wdata = wdata_q;
               data_d    = wdata_q;
            end
            if (op_q == OP_READ || op_q == OP_WRITE) begin
               state_d = StResp;
               ack_d   = 1'b1;
               rdata_d = data_d;
`ifdef MEM_PARITY_EN
               perr_d  = ~mem_rpar_ok;
`endif
            end else begin
               state_d = StModify;
            end
         end
         StModify: begin
            mem_we    = 1'b1;
            mem_wdata = modified;
            data_d    = modified;
            state_d   = StResp;
            ack_d     = 1'b1;
            rdata_d   = modified;
`ifdef MEM_PARITY_EN
            perr_d    = bad_par_q;
`endif
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   // Reset drops state to IDLE at once, so mem_we is low for any aborted write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         op_q      <= 2'b00;
         addr_q    <= '0;
         wdata_q   <= '0;
         data_q    <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
`ifdef MEM_PARITY_EN
         bad_par_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
`ifdef MEM_PARITY_EN
         bad_par_q <= bad_par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign ack   = ack_q;
   assign rdata = rdata_q;
   assign busy  = busy_q;
`ifdef MEM_PARITY_EN
   assign perr  = perr_q;
`endif

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .raddr   (addr_q),
      .rdata   (mem_rdata)
`ifdef MEM_PARITY_EN
      ,
      .rpar_ok (mem_rpar_ok)
`endif
   );

endmodule
